// File: rtl/serial_word_assembler_pkg.sv
// Shared types and helpers for the serial word assembler.
//   hold_state_t  : holding-register state (EMPTY / FULL)
//   DEFAULT_WIDTH : default assembled word length
//   count_w()     : width of a counter that indexes bits in a WIDTH-bit word
package serial_word_assembler_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int count_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_word_assembler_if.sv
// Serial-in / word-out handshake bundle for the serial word assembler.
//   bit_in, bit_valid : qualified serial bit stream into the assembler
//   word_out          : last completed word (held)
//   word_valid        : word_out holds an unconsumed word
//   word_ready        : downstream takes word_out this cycle
// Modports: slave = the assembler, master = the environment driving it.
interface serial_word_assembler_if
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             bit_in;
  logic             bit_valid;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;

  modport slave (
    input  bit_in, bit_valid, word_ready,
    output word_out, word_valid
  );

  modport master (
    output bit_in, bit_valid, word_ready,
    input  word_out, word_valid
  );
endinterface

// File: rtl/serial_word_assembler_word_shift_reg.sv
// Parameterised serial-in shift register.
//   clk, rst  : clock, asynchronous active-low reset
//   shift_en  : shift bit_in in on this edge
//   clr       : synchronous clear (wins over shift_en)
//   bit_in    : serial bit to insert
//   q         : current register contents
//   shifted   : value the register would take if shifted now; the
//               parent uses it as the completed word on the last bit
module word_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] shifted
);
  logic [WIDTH-1:0] q_reg;

  // MSB-first shifts left inserting at bit 0; LSB-first shifts right
  // inserting at the top bit, so the first bit ends up in bit 0.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (MSB_FIRST) begin : g_msb
      if (gi == 0) begin : g_ins
        assign shifted[gi] = bit_in;
      end else begin : g_mov
        assign shifted[gi] = q_reg[gi-1];
      end
    end else begin : g_lsb
      if (gi == WIDTH - 1) begin : g_ins
        assign shifted[gi] = bit_in;
      end else begin : g_mov
        assign shifted[gi] = q_reg[gi+1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (shift_en) begin
      q_reg <= shifted;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel front stage: collects one qualified bit per clock,
// assembles WIDTH-bit words and presents each on a held output with a
// valid/ready handshake.
//   clk, rst    : clock, asynchronous active-low reset
//   bus         : bit stream in, word_out/word_valid/word_ready out
//   sync_clr    : discard the partial word (frame resync)
//   clr_overrun : clear the sticky overrun flag
//   overrun     : a completed word was dropped while the holder was full
//   bit_count   : bits collected in the current partial word
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  serial_word_assembler_if.slave      bus,
  input  logic                        sync_clr,
  input  logic                        clr_overrun,
  output logic                        overrun,
  output logic [count_w(WIDTH)-1:0]   bit_count
);
  localparam int CNT_W = count_w(WIDTH);

  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] word_reg;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_word;
  logic             overrun_reg, overrun_next;
  hold_state_t      state_reg, state_next;
  logic             word_load;
  logic             overrun_set;
  logic             accept;
  logic             complete;

  // sync_clr discards any bit presented on the same edge.
  assign accept   = bus.bit_valid && !sync_clr;
  assign complete = accept && (count_reg == CNT_W'(WIDTH - 1));

  word_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .clr      (sync_clr || complete),
    .bit_in   (bus.bit_in),
    .q        (shift_q),
    .shifted  (shift_word)
  );

  always_comb begin
    count_next = count_reg;
    if (sync_clr || complete) begin
      count_next = '0;
    end else if (accept) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next  = state_reg;
    word_load   = 1'b0;
    overrun_set = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (complete) begin
          state_next = FULL;
          word_load  = 1'b1;
        end
      end
      FULL: begin
        if (complete) begin
          // A same-edge consume frees the holder for the new word.
          if (bus.word_ready) begin
            word_load = 1'b1;
          end else begin
            overrun_set = 1'b1;
          end
        end else if (bus.word_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Set beats clear when both happen on one edge.
  assign overrun_next = overrun_set || (overrun_reg && !clr_overrun);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg   <= '0;
      word_reg    <= '0;
      overrun_reg <= 1'b0;
      state_reg   <= EMPTY;
    end else begin
      count_reg   <= count_next;
      overrun_reg <= overrun_next;
      state_reg   <= state_next;
      if (word_load) begin
        word_reg <= shift_word;
      end
    end
  end

  assign bus.word_out   = word_reg;
  assign bus.word_valid = (state_reg == FULL);
  assign overrun        = overrun_reg;
  assign bit_count      = count_reg;
endmodule

// File: doc/serial_word_assembler.md
Name: serial_word_assembler

Overview:
Serial-to-parallel front stage. Accepts one qualified bit per clock and assembles WIDTH-bit words. Presents each completed word on a held output with a valid/ready handshake. Sits directly upstream of the 8-bit parallel register stage and drives that stage's data input with a stable word.

Parameters:
WIDTH, 8, word length in bits (≥2).
MSB_FIRST, 1, 1: first received bit lands in word_out[WIDTH-1]; 0: first bit lands in word_out[0].

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset.
bit_in  input  1  serial data bit.
bit_valid  input  1  bit_in is sampled on this clock edge.
sync_clr  input  1  synchronous frame resync; discards the partial word.
word_ready  input  1  downstream accepts word_out this cycle.
clr_overrun  input  1  synchronous clear of the overrun flag.
word_out  output  WIDTH  last completed word; held stable until replaced.
word_valid  output  1  word_out holds an unconsumed word.
overrun  output  1  sticky flag: a completed word was dropped.
bit_count  output  $clog2(WIDTH)  bits collected in the current partial word.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst=0, all state clears immediately, independent of clk:
  - shift register = 0, bit_count = 0;
  - word_out = 0, word_valid = 0, overrun = 0;
  - holding FSM = EMPTY.
- Collection path:
  - On each edge with bit_valid=1, bit_in shifts into the shift register and bit_count increments.
  - MSB_FIRST=1 shifts left, inserting at bit 0. MSB_FIRST=0 shifts right, inserting at bit WIDTH-1.
- Word completion:
  - Occurs on an edge with bit_valid=1 and bit_count=WIDTH-1.
  - The completed word is {shift register, bit_in} in MSB_FIRST order.
  - bit_count wraps to 0 and the shift register clears.
  - Collection continues without a gap: the next bit on the next cycle is accepted.
- Latency: the last bit sampled at edge k gives word_out/word_valid updated after edge k, visible in cycle k+1.
- Holding FSM, states EMPTY and FULL:
  - EMPTY + completion -> FULL; word_out loads, word_valid=1.
  - FULL + word_ready and no completion -> EMPTY; word_valid=0; word_out keeps its value and is not cleared.
  - FULL + word_ready + completion on the same edge -> stays FULL; word_out loads the new word; no overrun.
  - FULL + no word_ready + completion -> stays FULL; word_out unchanged (new word dropped); overrun set to 1.
  - word_ready while EMPTY is ignored.
- Overrun flag:
  - Sticky until clr_overrun=1 or reset.
  - If clr_overrun and a new overrun event occur on the same edge, set wins and overrun=1.
- sync_clr:
  - Clears the shift register and bit_count on that edge; any bit_valid that cycle is discarded.
  - Does not affect word_out, word_valid, overrun or the holding FSM.
- Reset asserted mid-word or while FULL: everything is lost; no word is emitted after reset release.
- word_out is fully registered; no combinational path from any input to any output.

Decomposition:
- Shared package:
  - hold_state_t enum {EMPTY, FULL};
  - default word width constant (8);
  - count-width helper function ($clog2-based).
- Natural sub-module: word_shift_reg.
  - Parameterised WIDTH/MSB_FIRST shifter with shift enable, synchronous clear and asynchronous active-low reset.
  - Top level keeps the bit counter, holding FSM and overrun logic.

Test Plan:
1. Reset: rst=0 mid-stream with 5 bits collected -> bit_count=0, word_valid=0, word_out=0, overrun=0 immediately; no word after release.
2. MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles, word_ready=1 -> word_out=8'hB2, word_valid high exactly one cycle after the 8th bit.
3. MSB_FIRST=0, same bit stream -> word_out=8'h4D; bit_valid gaps between bits do not change the result.
4. Back-pressure: word_ready=0, two full words 8'hA5 then 8'h3C -> word_out stays 8'hA5, overrun=1; clr_overrun pulse -> overrun=0, word_valid still 1.
5. Simultaneous: FULL with 8'h11, word_ready=1 on the completion edge of 8'h22 -> word_out=8'h22, word_valid stays 1, overrun=0.
6. sync_clr after 3 bits of 8'hFF, then 8 bits of 8'h0F -> word_out=8'h0F; a pending held word and overrun are unaffected.
